divisor_nb_ui: RTL

//   Parametrised successor of the 4-bit button-driven divider: operator enters numerator and

---
 rtl/divisor_nb_ui.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/divisor_nb_ui.sv
// Button-driven unsigned W-bit restoring divider with quotient/remainder display on LEDs.
// Define DIVISOR_DEBOUNCE_EN to insert a DEB_CYC-cycle debouncer after the synchronisers.
module divisor_nb_ui #(
  parameter int W       = 4,
  parameter int DEB_CYC = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up,
  input  logic         down,
  input  logic         ok,
  output logic [W-1:0] leds,
  output logic         busy,
  output logic         err
);

  typedef enum logic [2:0] {
    LOAD_N,
    LOAD_D,
    DIVIDE,
    SHOW_Q,
    SHOW_R,
    ERROR
  } state_t;

  localparam int CW = (W > 2) ? $clog2(W) : 1;

  if (W < 2 || W > 16 || DEB_CYC < 1) begin : g_param_check
    $error("divisor_nb_ui: W must be 2..16 and DEB_CYC at least 1");
  end

  state_t         state, next_state;
  logic [2:0]     btn_raw, sync1, sync2, lvl, lvl_q, press;
  logic           up_p, down_p, ok_p;
  logic [W-1:0]   num, den, quo, rem;
  logic [CW-1:0]  cnt;
  logic [W:0]     shifted, diff;
  logic           q_bit;

  assign btn_raw = {ok, down, up};

  // Buttons idle high, so the synchronisers reset to ones to avoid a false press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

`ifdef DIVISOR_DEBOUNCE_EN
  localparam int DW = $clog2(DEB_CYC + 1);

  logic [DW-1:0] deb_cnt [3];
  logic [2:0]    deb;

  // Debounced level follows the synchronised level only after DEB_CYC stable cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb <= '1;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DW'(DEB_CYC - 1)) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign lvl = deb;
`else
  assign lvl = sync2;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lvl_q <= '1;
    else      lvl_q <= lvl;
  end

  assign press  = lvl_q & ~lvl;
  assign up_p   = press[0];
  assign down_p = press[1];
  assign ok_p   = press[2];

  // One restoring step: a negative trial difference (top bit set) means quotient bit 0.
  assign shifted = {rem, quo[W-1]};
  assign diff    = shifted - {1'b0, den};
  assign q_bit   = ~diff[W];

  function automatic logic [W-1:0] bump(input logic [W-1:0] v, input logic inc, input logic dec);
    if (inc && !dec)      return v + 1'b1;
    else if (dec && !inc) return v - 1'b1;
    else                  return v;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= LOAD_N;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    leds       = '0;
    busy       = 1'b0;
    err        = 1'b0;
    case (state)
      LOAD_N: begin
        leds = num;
        if (ok_p) next_state = LOAD_D;
      end
      LOAD_D: begin
        leds = den;
        if (ok_p) next_state = (den == '0) ? ERROR : DIVIDE;
      end
      DIVIDE: begin
        leds = num;
        busy = 1'b1;
        if (cnt == CW'(W - 1)) next_state = SHOW_Q;
      end
      SHOW_Q: begin
        leds = quo;
        if (ok_p) next_state = SHOW_R;
      end
      SHOW_R: begin
        leds = rem;
        if (ok_p) next_state = LOAD_N;
      end
      ERROR: begin
        leds = '1;
        err  = 1'b1;
        if (ok_p) next_state = LOAD_N;
      end
      default: next_state = LOAD_N;
    endcase
  end

  // quo doubles as the dividend shift register: numerator bits leave at the top
  // while quotient bits enter at the bottom.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      num <= '0;
      den <= '0;
      quo <= '0;
      rem <= '0;
      cnt <= '0;
    end else begin
      case (state)
        LOAD_N: begin
          if (!ok_p) num <= bump(num, up_p, down_p);
        end
        LOAD_D: begin
          if (ok_p) begin
            if (den != '0) begin
              quo <= num;
              rem <= '0;
              cnt <= '0;
            end
          end else begin
            den <= bump(den, up_p, down_p);
          end
        end
        DIVIDE: begin
          quo <= {quo[W-2:0], q_bit};
          rem <= q_bit ? diff[W-1:0] : shifted[W-1:0];
          cnt <= cnt + 1'b1;
        end
        SHOW_R, ERROR: begin
          if (ok_p) begin
            num <= '0;
            den <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
